// File: rtl/icmp_msg_builder.sv
// ICMP message builder: captures the header fields and PAYLOAD_WORDS payload
// words, accumulates the Internet (one's-complement) checksum, then streams
// the complete message out under valid/ready flow control.
module icmp_msg_builder #(
    parameter int unsigned PAYLOAD_WORDS = 3
) (
    input  logic        clock,
    input  logic        hardreset,
    input  logic        start,
    input  logic [7:0]  typeoficmp,
    input  logic [7:0]  code,
    input  logic [31:0] typedata,
    input  logic        in_valid,
    input  logic [31:0] inputdata,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] outputmessage,
    output logic        out_last,
    output logic [15:0] checksum,
    output logic        busy,
    output logic        done
);

    localparam int unsigned IW       = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1;
    localparam logic [4:0]  LAST_IN  = 5'(PAYLOAD_WORDS - 1);
    localparam logic [4:0]  LAST_OUT = 5'(PAYLOAD_WORDS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FINAL,
        S_SEND
    } state_t;

    state_t      state;
    state_t      state_n;

    logic [7:0]  type_q;
    logic [7:0]  code_q;
    logic [31:0] tdata_q;
    logic [15:0] acc;
    logic [4:0]  widx;
    logic [4:0]  oidx;
    logic [31:0] buf_mem [PAYLOAD_WORDS];

    logic        accept;
    logic        accept_last;
    logic        fire;
    logic [4:0]  send_idx;
    logic [4:0]  buf_off;
    logic [31:0] send_word;

    // One's-complement 16-bit add with end-around carry.
    function automatic logic [15:0] add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

    // Handshake qualifiers for the input and output streams.
    always_comb begin
        accept      = (state == S_LOAD) && in_valid && in_ready;
        accept_last = accept && (widx == LAST_IN);
        fire        = (state == S_SEND) && out_valid && out_ready;
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (start) state_n = S_LOAD;
            S_LOAD:  if (accept_last) state_n = S_FINAL;
            S_FINAL: state_n = S_SEND;
            S_SEND:  if (fire && out_last) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (hardreset) state <= S_IDLE;
        else           state <= state_n;
    end

    // Select the word to present next: word 0 on SEND entry, else the
    // successor of the word currently being handed off.
    always_comb begin
        send_idx  = out_valid ? (oidx + 5'd1) : oidx;
        buf_off   = send_idx - 5'd2;
        send_word = '0;
        case (send_idx)
            5'd0:    send_word = {type_q, code_q, checksum};
            5'd1:    send_word = tdata_q;
            default: send_word = buf_mem[buf_off[IW-1:0]];
        endcase
    end

    // Payload storage; contents are don't-care after reset.
    always_ff @(posedge clock) begin
        if (accept) buf_mem[widx[IW-1:0]] <= inputdata;
    end

    // Datapath and registered outputs.
    always_ff @(posedge clock) begin
        if (hardreset) begin
            type_q        <= '0;
            code_q        <= '0;
            tdata_q       <= '0;
            acc           <= '0;
            widx          <= '0;
            oidx          <= '0;
            in_ready      <= 1'b0;
            out_valid     <= 1'b0;
            out_last      <= 1'b0;
            outputmessage <= '0;
            checksum      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            busy <= (state_n != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        type_q   <= typeoficmp;
                        code_q   <= code;
                        tdata_q  <= typedata;
                        acc      <= add16(add16({typeoficmp, code}, typedata[31:16]),
                                          typedata[15:0]);
                        widx     <= '0;
                        in_ready <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        acc  <= add16(add16(acc, inputdata[31:16]), inputdata[15:0]);
                        widx <= widx + 5'd1;
                        if (accept_last) in_ready <= 1'b0;
                    end
                end
                S_FINAL: begin
                    checksum <= ~acc;
                    oidx     <= '0;
                end
                S_SEND: begin
                    if (!out_valid) begin
                        out_valid     <= 1'b1;
                        outputmessage <= send_word;
                        out_last      <= (send_idx == LAST_OUT);
                    end else if (fire) begin
                        if (out_last) begin
                            out_valid     <= 1'b0;
                            out_last      <= 1'b0;
                            outputmessage <= '0;
                            done          <= 1'b1;
                        end else begin
                            oidx          <= oidx + 5'd1;
                            outputmessage <= send_word;
                            out_last      <= (send_idx == LAST_OUT);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_icmp_msg_builder.sv
// Self-checking bench for icmp_msg_builder: three builds (3, 1 and 16 payload
// words) driven by a table of known vectors, randomized messages checked
// against a checksum/word-list model, and a reset-abort sequence.
module tb_icmp_msg_builder;

    typedef logic [31:0] wq_t [$];

    typedef struct {
        logic [7:0]  ty;
        logic [7:0]  cd;
        logic [31:0] td;
        logic [31:0] pl [3];
        int          gap;
        int          bp;
        bit          noise;
        logic [15:0] exp_ck;
        logic [31:0] exp_w0;
    } vec_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic [2:0]       rst, start, in_valid, out_ready;
    logic [2:0]       in_ready, out_valid, out_last, busy, done;
    logic [2:0][7:0]  ty, cd;
    logic [2:0][31:0] td, indata, om;
    logic [2:0][15:0] ck;

    int pw_of [3] = '{3, 1, 16};
    int checks    = 0;
    int failures  = 0;
    int cur_k     = 0;

    icmp_msg_builder #(.PAYLOAD_WORDS(3)) u_dut3 (
        .clock(clock), .hardreset(rst[0]), .start(start[0]),
        .typeoficmp(ty[0]), .code(cd[0]), .typedata(td[0]),
        .in_valid(in_valid[0]), .inputdata(indata[0]), .in_ready(in_ready[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .outputmessage(om[0]),
        .out_last(out_last[0]), .checksum(ck[0]), .busy(busy[0]), .done(done[0]));

    icmp_msg_builder #(.PAYLOAD_WORDS(1)) u_dut1 (
        .clock(clock), .hardreset(rst[1]), .start(start[1]),
        .typeoficmp(ty[1]), .code(cd[1]), .typedata(td[1]),
        .in_valid(in_valid[1]), .inputdata(indata[1]), .in_ready(in_ready[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .outputmessage(om[1]),
        .out_last(out_last[1]), .checksum(ck[1]), .busy(busy[1]), .done(done[1]));

    icmp_msg_builder #(.PAYLOAD_WORDS(16)) u_dut16 (
        .clock(clock), .hardreset(rst[2]), .start(start[2]),
        .typeoficmp(ty[2]), .code(cd[2]), .typedata(td[2]),
        .in_valid(in_valid[2]), .inputdata(indata[2]), .in_ready(in_ready[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .outputmessage(om[2]),
        .out_last(out_last[2]), .checksum(ck[2]), .busy(busy[2]), .done(done[2]));

    // Internet checksum: sum all 16-bit halves wide, fold carries, invert.
    function automatic logic [15:0] model_ck(input logic [7:0] t, input logic [7:0] c,
                                             input logic [31:0] d, input wq_t pl);
        logic [31:0] s;
        s = {16'd0, t, c} + {16'd0, d[31:16]} + {16'd0, d[15:0]};
        foreach (pl[i]) s = s + {16'd0, pl[i][31:16]} + {16'd0, pl[i][15:0]};
        while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        return ~s[15:0];
    endfunction

    function automatic wq_t model_words(input logic [7:0] t, input logic [7:0] c,
                                        input logic [31:0] d, input wq_t pl);
        wq_t q;
        q.push_back({t, c, model_ck(t, c, d, pl)});
        q.push_back(d);
        foreach (pl[i]) q.push_back(pl[i]);
        return q;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s dut%0d got=%h exp=%h", name, cur_k, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Full message: start, load with optional gaps, collect with backpressure.
    task automatic run_msg(input int k, input logic [7:0] t, input logic [7:0] c,
                           input logic [31:0] d, input wq_t pl, input int gap,
                           input int bp, input bit noise, output wq_t got);
        wq_t         exp;
        logic [15:0] eck;
        int          cyc;
        int          ndone;
        bit          fin;
        logic        pv, prdy, pol, rdy;
        logic [31:0] pom;
        cur_k = k;
        exp   = model_words(t, c, d, pl);
        eck   = model_ck(t, c, d, pl);
        got   = {};
        ty[k] = t; cd[k] = c; td[k] = d; start[k] = 1'b1;
        tick();
        start[k] = 1'b0;
        ty[k] = 8'hEE; cd[k] = 8'hDD; td[k] = 32'hDEADBEEF;
        chk("busy_after_start", 32'(busy[k]), 32'd1);
        foreach (pl[i]) begin
            for (int g = 0; g < gap; g++) begin
                in_valid[k] = 1'b0;
                start[k] = noise;
                tick();
                start[k] = 1'b0;
                chk("in_ready_gap", 32'(in_ready[k]), 32'd1);
            end
            in_valid[k] = 1'b1;
            indata[k]   = pl[i];
            chk("in_ready_load", 32'(in_ready[k]), 32'd1);
            tick();
            in_valid[k] = 1'b0;
            indata[k]   = $urandom;
        end
        in_valid[k] = 1'b1;
        chk("in_ready_drop", 32'(in_ready[k]), 32'd0);
        chk("ov_lat0", 32'(out_valid[k]), 32'd0);
        tick();
        in_valid[k] = 1'b0;
        chk("ov_lat1", 32'(out_valid[k]), 32'd0);
        tick();
        chk("ov_lat2", 32'(out_valid[k]), 32'd1);
        cyc = 0; ndone = 0; fin = 1'b0; pv = 1'b0; prdy = 1'b0; pol = 1'b0; pom = '0;
        while (!fin && cyc < 400) begin
            if (pv && !prdy) begin
                chk("stall_valid", 32'(out_valid[k]), 32'd1);
                chk("stall_word", om[k], pom);
                chk("stall_last", 32'(out_last[k]), 32'(pol));
            end
            if (!out_valid[k]) chk("idle_zero", om[k], 32'd0);
            if (done[k]) ndone++;
            if (bp == 0)      rdy = 1'b1;
            else if (bp == 1) rdy = (cyc % 3 == 0);
            else              rdy = 1'($urandom_range(0, 1));
            out_ready[k] = rdy;
            start[k] = noise && (cyc % 4 == 1);
            if (out_valid[k] && rdy) begin
                got.push_back(om[k]);
                chk("out_last", 32'(out_last[k]), 32'(got.size() == exp.size()));
                if (out_last[k] || got.size() > exp.size()) fin = 1'b1;
            end
            pv = out_valid[k]; prdy = rdy; pom = om[k]; pol = out_last[k];
            tick();
            start[k] = 1'b0;
            cyc++;
        end
        out_ready[k] = 1'b0;
        chk("timeout", 32'(fin), 32'd1);
        chk("early_done", 32'(ndone), 32'd0);
        chk("done_pulse", 32'(done[k]), 32'd1);
        chk("ov_cleared", 32'(out_valid[k]), 32'd0);
        chk("last_cleared", 32'(out_last[k]), 32'd0);
        chk("om_cleared", om[k], 32'd0);
        chk("busy_end", 32'(busy[k]), 32'd0);
        chk("checksum", 32'(ck[k]), 32'(eck));
        chk("word_count", 32'(got.size()), 32'(exp.size()));
        foreach (exp[i]) if (i < got.size()) chk("word", got[i], exp[i]);
        tick();
        chk("done_once", 32'(done[k]), 32'd0);
        chk("checksum_hold", 32'(ck[k]), 32'(eck));
    endtask

    vec_t vecs [4];
    wq_t  pl, got;

    initial begin
        rst = '1; start = '0; in_valid = '0; out_ready = '0;
        ty = '0; cd = '0; td = '0; indata = '0;
        tick();
        start = '1; in_valid = '1; out_ready = '1;
        tick();
        rst = '0; start = '0; in_valid = '0; out_ready = '0;
        for (int k = 0; k < 3; k++) begin
            cur_k = k;
            chk("rst_busy", 32'(busy[k]), 32'd0);
            chk("rst_in_ready", 32'(in_ready[k]), 32'd0);
            chk("rst_out_valid", 32'(out_valid[k]), 32'd0);
            chk("rst_out_last", 32'(out_last[k]), 32'd0);
            chk("rst_om", om[k], 32'd0);
            chk("rst_ck", 32'(ck[k]), 32'd0);
            chk("rst_done", 32'(done[k]), 32'd0);
        end

        // Known-answer vectors on the 3-word build.
        vecs[0] = '{ty: 8'h08, cd: 8'h00, td: 32'h00010001,
                    pl: '{32'h61626364, 32'h65666768, 32'h696A6B6C},
                    gap: 0, bp: 0, noise: 1'b0, exp_ck: 16'h9191, exp_w0: 32'h08009191};
        vecs[1] = '{ty: 8'h00, cd: 8'h00, td: 32'h0,
                    pl: '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF},
                    gap: 0, bp: 0, noise: 1'b0, exp_ck: 16'h0000, exp_w0: 32'h00000000};
        vecs[2] = vecs[0];
        vecs[2].bp = 1;
        vecs[3] = vecs[0];
        vecs[3].gap = 2;
        vecs[3].noise = 1'b1;
        for (int v = 0; v < 4; v++) begin
            pl = {};
            for (int j = 0; j < 3; j++) pl.push_back(vecs[v].pl[j]);
            run_msg(0, vecs[v].ty, vecs[v].cd, vecs[v].td, pl,
                    vecs[v].gap, vecs[v].bp, vecs[v].noise, got);
            chk("tbl_ck", 32'(ck[0]), 32'(vecs[v].exp_ck));
            chk("tbl_w0", (got.size() > 0) ? got[0] : 32'hXXXXXXXX, vecs[v].exp_w0);
        end

        // Reset after the second payload word abandons the message.
        cur_k = 0;
        ty[0] = 8'h08; cd[0] = 8'h00; td[0] = 32'h00010001; start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        in_valid[0] = 1'b1; indata[0] = 32'h61626364;
        tick();
        indata[0] = 32'h65666768;
        tick();
        indata[0] = 32'h696A6B6C;
        rst[0] = 1'b1; start[0] = 1'b1; out_ready[0] = 1'b1;
        tick();
        rst[0] = 1'b0; start[0] = 1'b0; in_valid[0] = 1'b0;
        chk("abort_busy", 32'(busy[0]), 32'd0);
        chk("abort_in_ready", 32'(in_ready[0]), 32'd0);
        chk("abort_ck", 32'(ck[0]), 32'd0);
        chk("abort_ov", 32'(out_valid[0]), 32'd0);
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("abort_quiet_ov", 32'(out_valid[0]), 32'd0);
            chk("abort_quiet_done", 32'(done[0]), 32'd0);
        end
        out_ready[0] = 1'b0;
        pl = {32'h61626364, 32'h65666768, 32'h696A6B6C};
        run_msg(0, 8'h08, 8'h00, 32'h00010001, pl, 0, 0, 1'b0, got);
        chk("fresh_ck", 32'(ck[0]), 32'h9191);

        // Randomized messages on all three builds.
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 6; n++) begin
                pl = {};
                for (int j = 0; j < pw_of[k]; j++) begin
                    if (n == 1)      pl.push_back(32'hFFFFFFFF);
                    else if (n == 2) pl.push_back(32'h0);
                    else             pl.push_back($urandom);
                end
                run_msg(k, 8'($urandom), 8'($urandom), $urandom, pl,
                        $urandom_range(0, 2), $urandom_range(0, 2),
                        1'($urandom_range(0, 1)), got);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/icmp_msg_builder.md
ICMP_MSG_BUILDER -- requirements
Module: icmp_msg_builder

Interface
REQ-001 Parameter PAYLOAD_WORDS, default 3, number of 32-bit payload words per message; legal range 1..16.
REQ-002 clock  input  1  single clock; all logic on its rising edge.
REQ-003 hardreset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  begin a message; sampled only in IDLE.
REQ-005 typeoficmp  input  8  ICMP type; captured on accepted start.
REQ-006 code  input  8  ICMP code; captured on accepted start.
REQ-007 typedata  input  32  type-specific word (e.g. id/seq); captured on accepted start.
REQ-008 in_valid  input  1  inputdata valid.
REQ-009 inputdata  input  32  payload word.
REQ-010 in_ready  output  1  block accepts payload; high only in LOAD.
REQ-011 out_valid  output  1  outputmessage valid.
REQ-012 out_ready  input  1  downstream accepts outputmessage.
REQ-013 outputmessage  output  32  message word stream.
REQ-014 out_last  output  1  high with the final message word.
REQ-015 checksum  output  16  last computed checksum; holds until the next message's FINAL.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 done  output  1  one-cycle pulse after final word handshake.

Function
REQ-018 FSM states IDLE, LOAD, FINAL, SEND; all outputs registered.
REQ-019 IDLE: start=1 captures type/code/typedata, loads acc = add16(add16({typeoficmp,code}, typedata[31:16]), typedata[15:0]), clears word index, goes to LOAD; start ignored in all other states.
REQ-020 add16(a,b): 17-bit sum, carry bit added back into bit 0 (one's-complement end-around carry); result 16 bits.
REQ-021 LOAD: in_ready=1; each cycle with in_valid&in_ready stores inputdata in buffer[index], acc = add16(add16(acc, w[31:16]), w[15:0]), index+1.
REQ-022 LOAD: on acceptance of word PAYLOAD_WORDS-1, in_ready drops at the next edge and FSM goes to FINAL; no extra word is accepted.
REQ-023 in_valid=0 in LOAD stalls without state change; no timeout.
REQ-024 FINAL (one cycle): checksum = ~acc; go to SEND with output index 0.
REQ-025 SEND word order: 0 = {typeoficmp,code,checksum}; 1 = typedata; 2..PAYLOAD_WORDS+1 = buffer[0..PAYLOAD_WORDS-1]; total PAYLOAD_WORDS+2 words.
REQ-026 out_valid rises at the second rising edge after the edge accepting the last payload word.
REQ-027 While out_valid=1 and out_ready=0, outputmessage, out_last, out_valid hold stable.
REQ-028 Handshake (out_valid&out_ready) advances one word per cycle; out_ready high continuously yields back-to-back words.
REQ-029 out_last=1 only with word PAYLOAD_WORDS+1.
REQ-030 Handshake of the last word: out_valid/out_last cleared, done=1 for one cycle, FSM to IDLE; a start in the cycle after done is accepted.
REQ-031 outputmessage driven to 0 whenever out_valid=0.

Reset
REQ-032 hardreset=1 at a rising edge: state IDLE, in_ready=0, out_valid=0, out_last=0, outputmessage=0, checksum=0, busy=0, done=0, acc and indices 0; buffer contents need not be cleared.
REQ-033 hardreset dominates start, in_valid, out_ready in the same cycle; reset mid-LOAD or mid-SEND abandons the message with no done pulse.

Verification
REQ-034 PAYLOAD_WORDS=3, type 0x08, code 0x00, typedata 0x00010001, payload 0x61626364, 0x65666768, 0x696A6B6C, out_ready=1 -> words 0x08009191, 0x00010001, 0x61626364, 0x65666768, 0x696A6B6C; checksum=0x9191; out_last on word 5; done pulse once.
REQ-035 Carry wrap: type 0x00, code 0x00, typedata 0, payload 3 x 0xFFFFFFFF -> checksum 0x0000, first word 0x00000000.
REQ-036 Backpressure: case REQ-034 with out_ready toggling 1,0,0,1,... -> identical word sequence, words stable while stalled, no drop or duplicate.
REQ-037 Input gaps: in_valid low 2 cycles between each payload word -> same output as REQ-034; start pulsed during LOAD/SEND ignored.
REQ-038 hardreset asserted after 2nd payload word, then fresh REQ-034 message -> no output/done from aborted message; fresh message correct.
REQ-039 PAYLOAD_WORDS=1 and 16 builds: message length 3 and 18 words, checksum matches software one's-complement model.
